calc_requester: RTL

CALC_REQUESTER -- requirements
Module: calc_requester

---
 rtl/calc_requester.sv | 127 ++++++++++++
 1 files changed

// File: rtl/calc_requester.sv
// rtl/calc_requester.sv - request/response sequencer for an external 3-bit calculation datapath
//
// Accepts a host request (op, a, b), hands it to the datapath with dp_go held
// high until dp_done or a timeout, then presents the captured result alongside
// a locally computed reference and flags any disagreement.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   req_valid/req_ready       request handshake; req_op, req_a, req_b operands
//   dp_go, dp_op, dp_in1/2    command to the datapath (operands held registered)
//   dp_done, dp_out           datapath completion and result
//   rsp_valid/rsp_ack         response handshake
//   rsp_data, rsp_expected    captured result and reference result
//   rsp_mismatch, rsp_timeout response status flags
//   err_count                 saturating count of bad (mismatch/timeout) responses
module calc_requester #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [2:0] req_a,
  input  logic [2:0] req_b,
  output logic       dp_go,
  output logic [1:0] dp_op,
  output logic [2:0] dp_in1,
  output logic [2:0] dp_in2,
  input  logic       dp_done,
  input  logic [2:0] dp_out,
  output logic       rsp_valid,
  input  logic       rsp_ack,
  output logic [2:0] rsp_data,
  output logic [2:0] rsp_expected,
  output logic       rsp_mismatch,
  output logic       rsp_timeout,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  // Counter value on the last WAIT cycle before a timeout is declared; the
  // counter starts at 0, so this yields exactly TIMEOUT cycles of dp_go.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic [2:0] calc;
  logic       accept;
  logic       timeout_hit;
  logic       finish;
  logic       bad;

  assign req_ready   = (state == IDLE);
  assign dp_go       = (state == WAIT);
  assign rsp_valid   = (state == RESP);
  assign accept      = req_valid && req_ready;
  assign timeout_hit = (wait_cnt == LAST_CNT);
  assign finish      = (state == WAIT) && (dp_done || timeout_hit);
  // dp_done wins over a simultaneous timeout.
  assign bad         = dp_done ? (dp_out != calc) : 1'b1;

  always_comb begin
    calc = 3'd0;
    case (dp_op)
      2'b00:   calc = dp_in1 + dp_in2;
      2'b01:   calc = dp_in1 - dp_in2;
      2'b10:   calc = dp_in1 & dp_in2;
      default: calc = dp_in1 ^ dp_in2;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = WAIT;
      WAIT:    if (dp_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_op        <= 2'd0;
      dp_in1       <= 3'd0;
      dp_in2       <= 3'd0;
      wait_cnt     <= 8'd0;
      rsp_data     <= 3'd0;
      rsp_expected <= 3'd0;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
      err_count    <= 8'd0;
    end else begin
      if (accept) begin
        dp_op    <= req_op;
        dp_in1   <= req_a;
        dp_in2   <= req_b;
        wait_cnt <= 8'd0;
      end else if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end

      // Response fields are only written on RESP entry so they hold while
      // the host applies backpressure.
      if (finish) begin
        rsp_expected <= calc;
        rsp_data     <= dp_done ? dp_out : 3'd0;
        rsp_timeout  <= !dp_done;
        rsp_mismatch <= dp_done && (dp_out != calc);
        if (bad && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
